// File: rtl/mano_pkg.sv
// Shared encodings for the basic-computer timing-and-control sequencer:
// bus sources, ALU operations, opcodes and T-state values.
package mano_pkg;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_TR   = 3'd6;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    localparam logic [1:0] ALU_NONE = 2'b00;
    localparam logic [1:0] ALU_AND  = 2'b01;
    localparam logic [1:0] ALU_ADD  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_LDA  = 3'd2;
    localparam logic [2:0] OP_STA  = 3'd3;
    localparam logic [2:0] OP_BUN  = 3'd4;
    localparam logic [2:0] OP_BSA  = 3'd5;
    localparam logic [2:0] OP_ISZ  = 3'd6;
    localparam logic [2:0] OP_RRIO = 3'd7;

    localparam logic [3:0] T0 = 4'd0;
    localparam logic [3:0] T1 = 4'd1;
    localparam logic [3:0] T2 = 4'd2;
    localparam logic [3:0] T3 = 4'd3;
    localparam logic [3:0] T4 = 4'd4;
    localparam logic [3:0] T5 = 4'd5;
    localparam logic [3:0] T6 = 4'd6;

endpackage

// File: rtl/seq_counter.sv
// Sequence counter: synchronous clear (wins over increment), increment enable,
// asynchronous active-low reset.
module seq_counter #(
    parameter int unsigned W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_count = r_cnt;

endmodule

// File: rtl/mano_ctrl_seq.sv
// Timing-and-control sequencer: decodes the T-state, latched I bit and opcode into
// combinational register/bus/memory strobes for fetch, indirect and memory-reference execute.
module mano_ctrl_seq
    import mano_pkg::*;
#(
    parameter int unsigned SC_W = 4
) (
    input  logic            CLK,
    input  logic            RST_n,
    input  logic            run,
    input  logic [15:0]     ir,
    input  logic            dr_zero,
    output logic            ar_ld,
    output logic            ar_inr,
    output logic            ar_clr,
    output logic            pc_ld,
    output logic            pc_inr,
    output logic            pc_clr,
    output logic            dr_ld,
    output logic            dr_inr,
    output logic            ir_ld,
    output logic            ac_ld,
    output logic [1:0]      alu_op,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic [2:0]      bus_sel,
    output logic [SC_W-1:0] t_state,
    output logic            rr_exec,
    output logic            busy
);

    logic            w_sc_clr;
    logic            w_sc_inc;
    logic [SC_W-1:0] w_t;
    logic            r_i;
    logic [2:0]      r_opc;
    logic            w_unused_addr;

    seq_counter #(
        .W (SC_W)
    ) u_seq_counter (
        .i_clk   (CLK),
        .i_rst_n (RST_n),
        .i_clr   (w_sc_clr),
        .i_inc   (w_sc_inc),
        .o_count (w_t)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_i   <= 1'b0;
            r_opc <= OP_AND;
        end else if (w_t == T2) begin
            r_i   <= ir[15];
            r_opc <= ir[14:12];
        end
    end

    always_comb begin
        ar_ld    = 1'b0;
        ar_inr   = 1'b0;
        pc_ld    = 1'b0;
        pc_inr   = 1'b0;
        dr_ld    = 1'b0;
        dr_inr   = 1'b0;
        ir_ld    = 1'b0;
        ac_ld    = 1'b0;
        alu_op   = ALU_NONE;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        bus_sel  = BUS_NONE;
        rr_exec  = 1'b0;
        w_sc_clr = 1'b0;
        w_sc_inc = 1'b1;
        // Reset masks every strobe; the counter is held at zero by its own reset.
        if (RST_n) begin
            unique case (w_t)
                T0: begin
                    if (run) begin
                        bus_sel = BUS_PC;
                        ar_ld   = 1'b1;
                    end else begin
                        w_sc_inc = 1'b0;
                    end
                end
                T1: begin
                    bus_sel = BUS_MEM;
                    mem_rd  = 1'b1;
                    ir_ld   = 1'b1;
                    pc_inr  = 1'b1;
                end
                T2: begin
                    bus_sel = BUS_IR;
                    ar_ld   = 1'b1;
                end
                T3: begin
                    if (r_opc == OP_RRIO) begin
                        rr_exec  = 1'b1;
                        w_sc_clr = 1'b1;
                    end else if (r_i) begin
                        bus_sel = BUS_MEM;
                        mem_rd  = 1'b1;
                        ar_ld   = 1'b1;
                    end
                end
                T4: begin
                    unique case (r_opc)
                        OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                            bus_sel = BUS_MEM;
                            mem_rd  = 1'b1;
                            dr_ld   = 1'b1;
                        end
                        OP_STA: begin
                            bus_sel  = BUS_AC;
                            mem_wr   = 1'b1;
                            w_sc_clr = 1'b1;
                        end
                        OP_BUN: begin
                            bus_sel  = BUS_AR;
                            pc_ld    = 1'b1;
                            w_sc_clr = 1'b1;
                        end
                        OP_BSA: begin
                            bus_sel = BUS_PC;
                            mem_wr  = 1'b1;
                            ar_inr  = 1'b1;
                        end
                        default: w_sc_clr = 1'b1;
                    endcase
                end
                T5: begin
                    w_sc_clr = (r_opc != OP_ISZ);
                    unique case (r_opc)
                        OP_AND: begin ac_ld = 1'b1; alu_op = ALU_AND;  end
                        OP_ADD: begin ac_ld = 1'b1; alu_op = ALU_ADD;  end
                        OP_LDA: begin ac_ld = 1'b1; alu_op = ALU_PASS; end
                        OP_BSA: begin bus_sel = BUS_AR; pc_ld = 1'b1;  end
                        OP_ISZ: dr_inr = 1'b1;
                        default: ;
                    endcase
                end
                T6: begin
                    w_sc_clr = 1'b1;
                    if (r_opc == OP_ISZ) begin
                        bus_sel = BUS_DR;
                        mem_wr  = 1'b1;
                        pc_inr  = dr_zero;
                    end
                end
                default: begin
                    w_sc_clr = 1'b1;
                    w_sc_inc = 1'b0;
                end
            endcase
        end
    end

    assign ar_clr        = !RST_n;
    assign pc_clr        = !RST_n;
    assign t_state       = w_t;
    assign busy          = (w_t != '0);
    assign w_unused_addr = ^ir[11:0];

endmodule

// File: tb/tb_mano_ctrl_seq.sv
// Directed bench for mano_ctrl_seq: a per-cycle vector table of expected strobes
// plus hand sequences for reset and reset mid-instruction.
module tb_mano_ctrl_seq;
    import mano_pkg::*;

    localparam logic [13:0] S_AR_LD  = 14'h2000;
    localparam logic [13:0] S_AR_INR = 14'h1000;
    localparam logic [13:0] S_AR_CLR = 14'h0800;
    localparam logic [13:0] S_PC_LD  = 14'h0400;
    localparam logic [13:0] S_PC_INR = 14'h0200;
    localparam logic [13:0] S_PC_CLR = 14'h0100;
    localparam logic [13:0] S_DR_LD  = 14'h0080;
    localparam logic [13:0] S_DR_INR = 14'h0040;
    localparam logic [13:0] S_IR_LD  = 14'h0020;
    localparam logic [13:0] S_AC_LD  = 14'h0010;
    localparam logic [13:0] S_MEM_RD = 14'h0008;
    localparam logic [13:0] S_MEM_WR = 14'h0004;
    localparam logic [13:0] S_RR     = 14'h0002;
    localparam logic [13:0] S_BUSY   = 14'h0001;

    typedef struct {
        logic        run;
        logic [15:0] ir;
        logic        dz;
        logic [3:0]  t;
        logic [2:0]  bus;
        logic [1:0]  alu;
        logic [13:0] strb;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic        run;
    logic [15:0] ir;
    logic        dr_zero;
    logic        ar_ld, ar_inr, ar_clr, pc_ld, pc_inr, pc_clr;
    logic        dr_ld, dr_inr, ir_ld, ac_ld, mem_rd, mem_wr, rr_exec, busy;
    logic [1:0]  alu_op;
    logic [2:0]  bus_sel;
    logic [3:0]  t_state;
    logic [13:0] act_strb;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs[$];

    mano_ctrl_seq #(
        .SC_W (4)
    ) dut (
        .CLK     (CLK),
        .RST_n   (RST_n),
        .run     (run),
        .ir      (ir),
        .dr_zero (dr_zero),
        .ar_ld   (ar_ld),
        .ar_inr  (ar_inr),
        .ar_clr  (ar_clr),
        .pc_ld   (pc_ld),
        .pc_inr  (pc_inr),
        .pc_clr  (pc_clr),
        .dr_ld   (dr_ld),
        .dr_inr  (dr_inr),
        .ir_ld   (ir_ld),
        .ac_ld   (ac_ld),
        .alu_op  (alu_op),
        .mem_rd  (mem_rd),
        .mem_wr  (mem_wr),
        .bus_sel (bus_sel),
        .t_state (t_state),
        .rr_exec (rr_exec),
        .busy    (busy)
    );

    always #5 CLK = ~CLK;

    assign act_strb = {ar_ld, ar_inr, ar_clr, pc_ld, pc_inr, pc_clr, dr_ld, dr_inr,
                       ir_ld, ac_ld, mem_rd, mem_wr, rr_exec, busy};

    task automatic check(input string name, input logic [3:0] et, input logic [2:0] eb,
                         input logic [1:0] ea, input logic [13:0] es);
        n_checks++;
        if (t_state !== et || bus_sel !== eb || alu_op !== ea || act_strb !== es) begin
            n_errors++;
            $display("FAIL %s: got t=%0d bus=%0d alu=%b strb=%h, expected t=%0d bus=%0d alu=%b strb=%h",
                     name, t_state, bus_sel, alu_op, act_strb, et, eb, ea, es);
        end
    endtask

    task automatic add(input logic r, input logic [15:0] i, input logic dz, input logic [3:0] t,
                       input logic [2:0] b, input logic [1:0] a, input logic [13:0] s);
        vec_t v;
        v.run = r; v.ir = i; v.dz = dz; v.t = t; v.bus = b; v.alu = a;
        v.strb = s | ((t != 4'd0) ? S_BUSY : 14'h0);
        vecs.push_back(v);
    endtask

    task automatic fetch(input logic [15:0] i, input logic dz);
        add(1'b1, i, dz, 4'd0, BUS_PC,  ALU_NONE, S_AR_LD);
        add(1'b1, i, dz, 4'd1, BUS_MEM, ALU_NONE, S_MEM_RD | S_IR_LD | S_PC_INR);
        add(1'b1, i, dz, 4'd2, BUS_IR,  ALU_NONE, S_AR_LD);
    endtask

    initial begin
        RST_n = 1'b0; run = 1'b0; ir = 16'h0; dr_zero = 1'b0;

        // ADD direct
        fetch(16'h1123, 1'b0);
        add(1'b1, 16'h1123, 1'b0, 4'd3, BUS_NONE, ALU_NONE, 14'h0);
        add(1'b1, 16'h1123, 1'b0, 4'd4, BUS_MEM,  ALU_NONE, S_MEM_RD | S_DR_LD);
        add(1'b1, 16'h1123, 1'b0, 4'd5, BUS_NONE, ALU_ADD,  S_AC_LD);
        // AND indirect
        fetch(16'h8300, 1'b0);
        add(1'b1, 16'h8300, 1'b0, 4'd3, BUS_MEM,  ALU_NONE, S_MEM_RD | S_AR_LD);
        add(1'b1, 16'h8300, 1'b0, 4'd4, BUS_MEM,  ALU_NONE, S_MEM_RD | S_DR_LD);
        add(1'b1, 16'h8300, 1'b0, 4'd5, BUS_NONE, ALU_AND,  S_AC_LD);
        // LDA
        fetch(16'h2010, 1'b0);
        add(1'b1, 16'h2010, 1'b0, 4'd3, BUS_NONE, ALU_NONE, 14'h0);
        add(1'b1, 16'h2010, 1'b0, 4'd4, BUS_MEM,  ALU_NONE, S_MEM_RD | S_DR_LD);
        add(1'b1, 16'h2010, 1'b0, 4'd5, BUS_NONE, ALU_PASS, S_AC_LD);
        // STA
        fetch(16'h3040, 1'b0);
        add(1'b1, 16'h3040, 1'b0, 4'd3, BUS_NONE, ALU_NONE, 14'h0);
        add(1'b1, 16'h3040, 1'b0, 4'd4, BUS_AC,   ALU_NONE, S_MEM_WR);
        // BUN
        fetch(16'h4020, 1'b0);
        add(1'b1, 16'h4020, 1'b0, 4'd3, BUS_NONE, ALU_NONE, 14'h0);
        add(1'b1, 16'h4020, 1'b0, 4'd4, BUS_AR,   ALU_NONE, S_PC_LD);
        // BSA
        fetch(16'h5010, 1'b0);
        add(1'b1, 16'h5010, 1'b0, 4'd3, BUS_NONE, ALU_NONE, 14'h0);
        add(1'b1, 16'h5010, 1'b0, 4'd4, BUS_PC,   ALU_NONE, S_MEM_WR | S_AR_INR);
        add(1'b1, 16'h5010, 1'b0, 4'd5, BUS_AR,   ALU_NONE, S_PC_LD);
        // ISZ, dr_zero=1 then dr_zero=0
        for (int k = 0; k < 2; k++) begin
            logic dz;
            dz = (k == 0);
            fetch(16'h6050, dz);
            add(1'b1, 16'h6050, dz, 4'd3, BUS_NONE, ALU_NONE, 14'h0);
            add(1'b1, 16'h6050, dz, 4'd4, BUS_MEM,  ALU_NONE, S_MEM_RD | S_DR_LD);
            add(1'b1, 16'h6050, dz, 4'd5, BUS_NONE, ALU_NONE, S_DR_INR);
            add(1'b1, 16'h6050, dz, 4'd6, BUS_DR,   ALU_NONE,
                S_MEM_WR | (dz ? S_PC_INR : 14'h0));
        end
        // Register-reference hand-off
        fetch(16'h7800, 1'b0);
        add(1'b1, 16'h7800, 1'b0, 4'd3, BUS_NONE, ALU_NONE, S_RR);
        // ADD with run dropping after T0: completes, then halts
        add(1'b1, 16'h1123, 1'b0, 4'd0, BUS_PC,   ALU_NONE, S_AR_LD);
        add(1'b0, 16'h1123, 1'b0, 4'd1, BUS_MEM,  ALU_NONE, S_MEM_RD | S_IR_LD | S_PC_INR);
        add(1'b0, 16'h1123, 1'b0, 4'd2, BUS_IR,   ALU_NONE, S_AR_LD);
        add(1'b0, 16'h1123, 1'b0, 4'd3, BUS_NONE, ALU_NONE, 14'h0);
        add(1'b0, 16'h1123, 1'b0, 4'd4, BUS_MEM,  ALU_NONE, S_MEM_RD | S_DR_LD);
        add(1'b0, 16'h1123, 1'b0, 4'd5, BUS_NONE, ALU_ADD,  S_AC_LD);
        add(1'b0, 16'h1123, 1'b0, 4'd0, BUS_NONE, ALU_NONE, 14'h0);
        add(1'b0, 16'h1123, 1'b0, 4'd0, BUS_NONE, ALU_NONE, 14'h0);

        #3;
        check("reset_state", 4'd0, BUS_NONE, ALU_NONE, S_AR_CLR | S_PC_CLR);
        @(negedge CLK);
        RST_n = 1'b1;
        #1;
        check("reset_release", 4'd0, BUS_NONE, ALU_NONE, 14'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            #1;
            check($sformatf("halt_idle%0d", c), 4'd0, BUS_NONE, ALU_NONE, 14'h0);
        end

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge CLK);
            run = vecs[k].run; ir = vecs[k].ir; dr_zero = vecs[k].dz;
            #1;
            check($sformatf("vec%0d_t%0d_ir%h", k, vecs[k].t, vecs[k].ir),
                  vecs[k].t, vecs[k].bus, vecs[k].alu, vecs[k].strb);
        end

        // Reset asserted during T4 of an ADD
        @(negedge CLK);
        run = 1'b1; ir = 16'h1123;
        for (int c = 0; c < 4; c++) @(negedge CLK);
        #1;
        check("pre_reset_t4", 4'd4, BUS_MEM, ALU_NONE, S_MEM_RD | S_DR_LD | S_BUSY);
        RST_n = 1'b0;
        #1;
        check("mid_reset", 4'd0, BUS_NONE, ALU_NONE, S_AR_CLR | S_PC_CLR);
        @(negedge CLK);
        #1;
        check("mid_reset_hold", 4'd0, BUS_NONE, ALU_NONE, S_AR_CLR | S_PC_CLR);
        run = 1'b0;
        RST_n = 1'b1;
        @(negedge CLK);
        #1;
        check("post_reset_idle", 4'd0, BUS_NONE, ALU_NONE, 14'h0);
        run = 1'b1;
        #1;
        check("post_reset_t0", 4'd0, BUS_PC, ALU_NONE, S_AR_LD);
        @(negedge CLK);
        #1;
        check("post_reset_t1", 4'd1, BUS_MEM, ALU_NONE, S_MEM_RD | S_IR_LD | S_PC_INR | S_BUSY);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mano_ctrl_seq.md
Name: mano_ctrl_seq

Overview:
- Timing-and-control sequencer for the basic-computer datapath.
- A 4-bit sequence counter steps T0..T6. Each T-state decodes into load/increment/clear strobes for AR, PC, DR, IR and AC, plus common-bus select and memory read/write.
- Covers instruction fetch, decode, indirect-address resolution and all seven memory-reference instructions.
- For register-reference and I/O instructions (opcode 7), it hands off through a one-cycle strobe.

Parameters:
- SC_W, 4, sequence-counter width; T-states 0..6 used.

Ports:
- CLK  in  1  system clock, rising edge
- RST_n  in  1  asynchronous active-low reset
- run  in  1  start/continue execution; sampled only in T0
- ir  in  16  current IR contents: [15]=I bit, [14:12]=opcode, [11:0]=address
- dr_zero  in  1  DR==0 after increment; used in ISZ T6
- ar_ld, ar_inr, ar_clr  out  1 each  AR control
- pc_ld, pc_inr, pc_clr  out  1 each  PC control
- dr_ld, dr_inr  out  1 each  DR control
- ir_ld  out  1  IR load
- ac_ld  out  1  AC load from ALU
- alu_op  out  2  00 none, 01 AND, 10 ADD, 11 pass DR
- mem_rd, mem_wr  out  1 each  memory strobes
- bus_sel  out  3  1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM, 0 none
- t_state  out  4  current sequence-counter value
- rr_exec  out  1  one-cycle strobe: register-ref/IO instruction in execute
- busy  out  1  high whenever t_state != 0

Behaviour:
- Reset:
  - RST_n low forces t_state=0, latched I=0 and opcode=0.
  - All strobes, alu_op and bus_sel are 0, except ar_clr and pc_clr.
  - ar_clr = pc_clr = !RST_n, combinational, so AR and PC clear asynchronously with the controller.
- Output timing:
  - Strobes are combinational from the registered t_state, I and opcode.
  - Each strobe is valid for the whole T-cycle; its effect lands at the rising edge that ends the cycle.
- Sequence counter:
  - Increments each edge.
  - Returns to 0 ("SC<-0") at the end of each instruction's last T-state.
- T0:
  - If run=1: bus_sel=2, ar_ld (AR<-PC).
  - If run=0: all strobes 0 and t_state holds at 0 (halt).
- T1: bus_sel=7, mem_rd, ir_ld, pc_inr.
- T2:
  - bus_sel=5, ar_ld (AR<-IR[11:0]).
  - Latch I=ir[15] and opcode=ir[14:12] at the closing edge.
- T3:
  - opcode=7: rr_exec=1, then SC<-0.
  - opcode!=7 and I=1: bus_sel=7, mem_rd, ar_ld (indirect).
  - opcode!=7 and I=0: no strobes.
- AND/ADD/LDA (opcodes 0/1/2):
  - T4: bus_sel=7, mem_rd, dr_ld.
  - T5: ac_ld, alu_op = 01/10/11 respectively, then SC<-0.
- STA (3): T4: bus_sel=4, mem_wr, then SC<-0.
- BUN (4): T4: bus_sel=1, pc_ld, then SC<-0.
- BSA (5):
  - T4: bus_sel=2, mem_wr, ar_inr.
  - T5: bus_sel=1, pc_ld, then SC<-0.
- ISZ (6):
  - T4: bus_sel=7, mem_rd, dr_ld.
  - T5: dr_inr.
  - T6: bus_sel=3, mem_wr, pc_inr iff dr_zero, then SC<-0.
- Boundary conditions:
  - run falling mid-instruction has no effect; the instruction completes and the block halts at the next T0.
  - Reset mid-instruction aborts immediately with no further strobes.
  - At most one of ar_ld/ar_inr/ar_clr is active in any cycle; likewise for PC and DR.
  - t_state never exceeds 6. An illegal state returns to 0 with no strobes.
  - bus_sel is nonzero only when some register or memory is being loaded from the bus.

Decomposition:
- Shared package mano_pkg holds:
  - bus_sel codes BUS_AR..BUS_MEM
  - ALU_NONE/AND/ADD/PASS
  - opcode constants OP_AND..OP_RRIO
  - T-state constants T0..T6
- One sub-module, seq_counter: SC_W-bit counter with synchronous clear, increment enable and async active-low reset.

Test Plan:
- Reset, then run=0 for 5 cycles:
  - t_state stays 0.
  - ar_clr and pc_clr high only while RST_n=0.
  - All other strobes 0.
- run=1, ir=16'h1123 (ADD direct 0x123): at T0..T5 the expected outputs are:
  - T0: bus_sel 2 with ar_ld
  - T1: 7 with mem_rd/ir_ld/pc_inr
  - T2: 5 with ar_ld
  - T3: none
  - T4: 7 with mem_rd/dr_ld
  - T5: ac_ld with alu_op=10
  - Then t_state returns to 0.
- ir=16'h8300 (AND indirect): T3 shows bus_sel=7, mem_rd, ar_ld; T5 has alu_op=01.
- ir=16'h6050 (ISZ):
  - T5: dr_inr.
  - T6 with dr_zero=1: mem_wr, bus_sel=3, pc_inr.
  - Repeat with dr_zero=0: pc_inr stays 0.
- ir=16'h5010 (BSA): T4 asserts mem_wr, bus_sel=2, ar_inr; T5 asserts pc_ld, bus_sel=1.
- Control edge cases:
  - ir=16'h7800: rr_exec high for one cycle at T3, then back to T0.
  - RST_n low at T4 of an ADD: all strobes drop to 0 that cycle and t_state=0.
